// File: rtl/hamming_codec_arb_pkg.sv
// Shared types and constants for the two-requester Hamming(7,4) codec.
package hamming_codec_arb_pkg;

    // Arbiter/response FSM states.
    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    // Per-requester operation encodings.
    localparam logic OP_ENC = 1'b0;
    localparam logic OP_DEC = 1'b1;

    // Default width of the corrected-error counter.
    localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/hamming_codec_arb_codec.sv
// Combinational Hamming(7,4) encoder and single-error-correcting decoder.
// Codeword bit i carries Hamming position i+1: {d3,d2,d1,p4,d0,p2,p1}.
module hamming74_codec (
    input  logic [3:0] data_i,
    input  logic [6:0] cw_i,
    output logic [6:0] cw_o,
    output logic [3:0] data_o,
    output logic [2:0] syn_o
);

    logic [6:0] fixed_cw;

    // Encoder: data bits in positions 3,5,6,7, parity bits in 1,2,4.
    assign cw_o[0] = data_i[0] ^ data_i[1] ^ data_i[3];
    assign cw_o[1] = data_i[0] ^ data_i[2] ^ data_i[3];
    assign cw_o[2] = data_i[0];
    assign cw_o[3] = data_i[1] ^ data_i[2] ^ data_i[3];
    assign cw_o[4] = data_i[1];
    assign cw_o[5] = data_i[2];
    assign cw_o[6] = data_i[3];

    // Syndrome {s4,s2,s1}: each bit checks every position its parity covers.
    assign syn_o[0] = cw_i[0] ^ cw_i[2] ^ cw_i[4] ^ cw_i[6];
    assign syn_o[1] = cw_i[1] ^ cw_i[2] ^ cw_i[5] ^ cw_i[6];
    assign syn_o[2] = cw_i[3] ^ cw_i[4] ^ cw_i[5] ^ cw_i[6];

    // Flip the bit the syndrome points at, then pull out the data positions.
    always_comb begin
        // NOTE: assign a default first so every path drives the signal and no latch is inferred.
        fixed_cw = cw_i;
        if (syn_o != 3'd0) begin
            fixed_cw[syn_o - 3'd1] = ~cw_i[syn_o - 3'd1];
        end
        data_o = {fixed_cw[6], fixed_cw[5], fixed_cw[4], fixed_cw[2]};
    end

endmodule

// File: rtl/hamming_codec_arb.sv
// Two-requester round-robin front end sharing one Hamming(7,4) codec.
// One request is accepted in IDLE, its result is registered and held in
// RESP until the consumer takes it.
module hamming_codec_arb
    import hamming_codec_arb_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_op,
    input  logic [13:0]      req_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [6:0]       rsp_data,
    output logic [2:0]       rsp_syn,
    output logic             rsp_corr,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             cnt_clr
);

    state_e           state_q, state_d;
    logic             last_q;
    logic             grant_vld;
    logic             grant_id;
    logic             accept;
    logic             sel_op;
    logic [6:0]       sel_data;
    logic [6:0]       enc_cw;
    logic [3:0]       dec_data;
    logic [2:0]       dec_syn;
    logic             rsp_id_q;
    logic [6:0]       rsp_data_q, rsp_data_d;
    logic [2:0]       rsp_syn_q, rsp_syn_d;
    logic             rsp_corr_q, rsp_corr_d;
    logic [CNT_W-1:0] err_cnt_q;

    // Round-robin grant: a lone requester wins, contention goes to the one not granted last.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        case (req_valid)
            2'b01:   begin grant_vld = 1'b1; grant_id = 1'b0;    end
            2'b10:   begin grant_vld = 1'b1; grant_id = 1'b1;    end
            2'b11:   begin grant_vld = 1'b1; grant_id = ~last_q; end
            default: begin grant_vld = 1'b0; grant_id = 1'b0;    end
        endcase
    end

    // Next-state and req_ready; ready is suppressed while reset is held.
    always_comb begin
        state_d   = state_q;
        req_ready = 2'b00;
        case (state_q)
            IDLE: begin
                if (grant_vld && !rst) begin
                    req_ready[grant_id] = 1'b1;
                    state_d             = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = |(req_valid & req_ready);

    // Route the granted requester's op and payload into the shared codec.
    assign sel_op   = req_op[grant_id];
    assign sel_data = grant_id ? req_data[13:7] : req_data[6:0];

    hamming74_codec u_codec (
        .data_i (sel_data[3:0]),
        .cw_i   (sel_data),
        .cw_o   (enc_cw),
        .data_o (dec_data),
        .syn_o  (dec_syn)
    );

    // Result captured on acceptance: codeword for encode, corrected data for decode.
    always_comb begin
        rsp_data_d = enc_cw;
        rsp_syn_d  = 3'd0;
        rsp_corr_d = 1'b0;
        if (sel_op == OP_DEC) begin
            rsp_data_d = {3'b000, dec_data};
            rsp_syn_d  = dec_syn;
            rsp_corr_d = (dec_syn != 3'd0);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Response registers and last-grant pointer, loaded only on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: last_q resets to B so that A wins the first contention.
        if (rst) begin
            last_q     <= 1'b1;
            rsp_id_q   <= 1'b0;
            rsp_data_q <= 7'd0;
            rsp_syn_q  <= 3'd0;
            rsp_corr_q <= 1'b0;
        end else if (accept) begin
            last_q     <= grant_id;
            rsp_id_q   <= grant_id;
            rsp_data_q <= rsp_data_d;
            rsp_syn_q  <= rsp_syn_d;
            rsp_corr_q <= rsp_corr_d;
        end
    end

    // Saturating corrected-decode counter; a clear beats a coincident increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (cnt_clr) begin
            err_cnt_q <= '0;
        end else if (accept && rsp_corr_d && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_syn   = rsp_syn_q;
    assign rsp_corr  = rsp_corr_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: doc/hamming_codec_arb.md
HAMMING_CODEC_ARB -- requirements
Module: hamming_codec_arb

Interface
REQ-001 Parameter CNT_W, default 8: width of the corrected-error counter.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 req_valid  input  2  per-requester request valid; index 0 = requester A, index 1 = requester B.
REQ-005 req_ready  output  2  per-requester accept; at most one bit high in any cycle.
REQ-006 req_op  input  2  per-requester operation: 0 = encode, 1 = decode.
REQ-007 req_data  input  14  per-requester payload, 7 bits each; requester n uses bits [7n+6:7n]; encode uses only [3:0] of its slice.
REQ-008 rsp_valid  output  1  response valid.
REQ-009 rsp_ready  input  1  response consumer accept.
REQ-010 rsp_id  output  1  index of the requester that owns the response.
REQ-011 rsp_data  output  7  encode: 7-bit codeword; decode: {3'b0, corrected 4-bit data}.
REQ-012 rsp_syn  output  3  decode syndrome; 0 for encode.
REQ-013 rsp_corr  output  1  decode with nonzero syndrome; 0 for encode.
REQ-014 err_cnt  output  CNT_W  saturating count of corrected decodes.
REQ-015 cnt_clr  input  1  synchronous clear of err_cnt.

Function
REQ-016 Codeword bit i holds Hamming position i+1: [0]=p1, [1]=p2, [2]=d0, [3]=p4, [4]=d1, [5]=d2, [6]=d3.
REQ-017 Parity definitions: p1 = d0^d1^d3; p2 = d0^d2^d3; p4 = d1^d2^d3.
REQ-018 Syndrome is {s4,s2,s1}, with each bit the XOR of all codeword positions covered by that parity bit.
REQ-019 A nonzero syndrome S inverts codeword bit S-1 before data extraction.
REQ-020 FSM has two states: IDLE and RESP.
REQ-021 In IDLE, req_ready is high for the granted requester only; grant goes to the single valid requester; if both are valid, grant goes to the requester not granted last (round-robin).
REQ-022 Acceptance occurs when req_valid and req_ready are both high; the FSM then moves to RESP and registers the selected op/data result on the same edge.
REQ-023 Latency is fixed: rsp_valid goes high in the cycle after acceptance.
REQ-024 In RESP, req_ready is 0 and all rsp_* outputs are held stable until rsp_valid and rsp_ready are both high; the FSM then returns to IDLE. No request is accepted in that same cycle, so at most one request is accepted every 2 cycles.
REQ-025 The last-grant pointer updates only on acceptance.
REQ-026 err_cnt increments by 1 on acceptance of a decode whose syndrome is nonzero, and holds at 2^CNT_W-1 once reached.
REQ-027 If cnt_clr coincides with an increment, the clear wins and err_cnt = 0.
REQ-028 req_valid may drop before it is accepted; in that case there is no acceptance and no state change.

Reset
REQ-029 While rst is high: state = IDLE, rsp_valid = 0, rsp_id/rsp_data/rsp_syn/rsp_corr = 0, err_cnt = 0, last-grant = 1 (requester A wins the first contention), req_ready = 0.
REQ-030 Asserting rst while in RESP discards the pending response with no handshake.
REQ-031 The first acceptance can occur in the first cycle after rst deasserts.

Structure
REQ-032 A shared package holds: state enum {IDLE, RESP}, op encodings OP_ENC = 0 and OP_DEC = 1, and the default value of CNT_W.
REQ-033 The combinational codec is a sub-module, hamming74_codec (data in, codeword in, codeword out, corrected data out, syndrome out), instantiated once and shared by both requesters.

Verification
REQ-034 Encode: reset, A encode data 4'hB -> one cycle later rsp_valid=1, rsp_id=0, rsp_data=7'h55, rsp_syn=0, rsp_corr=0.
REQ-035 Single-bit error: B decode 7'h45 (bit 4 flipped) -> rsp_data=7'h0B, rsp_syn=5, rsp_corr=1, err_cnt increments by 1. Clean decode 7'h55 -> syn=0, corr=0, err_cnt unchanged.
REQ-036 Arbitration: A and B valid together in every cycle, rsp_ready tied high -> grants alternate 0,1,0,1 and an acceptance occurs every 2 cycles.
REQ-037 Backpressure: rsp_ready=0 for 5 cycles -> rsp_* outputs stable and req_ready=0 throughout; rsp_ready=1 -> handshake, IDLE on the next cycle.
REQ-038 Counter: CNT_W=2 with 4 erroneous decodes -> err_cnt stays at 3. cnt_clr asserted in the same cycle as an erroneous decode acceptance -> err_cnt=0.
REQ-039 Reset in RESP: assert rst with rsp_valid=1 -> rsp_valid=0 immediately (asynchronous), state IDLE; next contention is granted to A.
